// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN command decoder slice.
package snn_pkg;
    localparam int NUM_CMDS = 10;
    localparam int CMD_ID_W = 4;

    typedef logic [CMD_ID_W-1:0] cmd_id_t;

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_SCAN,
        ST_DECIDE,
        ST_EMIT
    } dec_state_t;
endpackage

// File: rtl/snn_cmd_count_bank.sv
// Bank of per-class saturating spike counters with a vector add, a bulk clear
// and one index-addressed read port for the sequential argmax scan.
module snn_cmd_count_bank
    import snn_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                add_en,
    input  logic [NUM_CMDS-1:0] add_vec,
    input  logic                clear,
    input  logic [CMD_ID_W-1:0] rd_idx,
    output logic [COUNT_W-1:0]  rd_data
);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [COUNT_W-1:0] count_q [NUM_CMDS];

    // NOTE: state updates use <= so every counter sees pre-edge values, and the
    // bank is reset explicitly because a leftover count would bias the next window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CMDS; i++) count_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_CMDS; i++) count_q[i] <= '0;
        end else if (add_en) begin
            for (int i = 0; i < NUM_CMDS; i++) begin
                if (add_vec[i] && (count_q[i] != COUNT_MAX)) count_q[i] <= count_q[i] + 1'b1;
            end
        end
    end

    assign rd_data = (int'(rd_idx) < NUM_CMDS) ? count_q[rd_idx] : '0;
endmodule

// File: rtl/snn_command_decoder.sv
// Windowed spike integration, sequential top-two argmax and confidence/margin
// gating; one decision per window is offered on a valid/ready handshake.
module snn_command_decoder
    import snn_pkg::*;
#(
    parameter int WINDOW     = 64,
    parameter int COUNT_W    = 8,
    parameter int MIN_COUNT  = 8,
    parameter int MIN_MARGIN = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_CMDS-1:0] cmd_spikes,
    input  logic                cmd_valid,
    output logic [CMD_ID_W-1:0] cmd_id,
    output logic [COUNT_W-1:0]  cmd_conf,
    output logic                cmd_out_valid,
    input  logic                cmd_out_ready,
    output logic                cmd_reject,
    output logic                overrun
);
    localparam int STEP_W = $clog2(WINDOW + 1);
    localparam logic [STEP_W-1:0]  STEP_LAST    = STEP_W'(WINDOW - 1);
    localparam logic [COUNT_W-1:0] MIN_COUNT_C  = COUNT_W'(MIN_COUNT);
    localparam logic [COUNT_W-1:0] MIN_MARGIN_C = COUNT_W'(MIN_MARGIN);
    localparam cmd_id_t            LAST_IDX     = cmd_id_t'(NUM_CMDS - 1);

    dec_state_t         state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    cmd_id_t            idx_q, idx_d;
    logic [COUNT_W-1:0] best_q, best_d, second_q, second_d;
    cmd_id_t            best_idx_q, best_idx_d;
    cmd_id_t            id_d;
    logic [COUNT_W-1:0] conf_d;
    logic               valid_d, reject_d, overrun_d;
    logic               add_en, clear;
    logic [COUNT_W-1:0] rd_data;

    snn_cmd_count_bank #(.COUNT_W(COUNT_W)) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .add_en  (add_en),
        .add_vec (cmd_spikes),
        .clear   (clear),
        .rd_idx  (idx_q),
        .rd_data (rd_data)
    );

    // NOTE: every signal gets its hold/idle value first so no branch can infer a latch.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        idx_d      = idx_q;
        best_d     = best_q;
        second_d   = second_q;
        best_idx_d = best_idx_q;
        id_d       = cmd_id;
        conf_d     = cmd_conf;
        valid_d    = cmd_out_valid;
        reject_d   = 1'b0;
        overrun_d  = cmd_valid && (state_q != ST_ACCUM);
        add_en     = 1'b0;
        clear      = 1'b0;

        unique case (state_q)
            ST_ACCUM: begin
                if (cmd_valid) begin
                    add_en = 1'b1;
                    if (step_q == STEP_LAST) begin
                        step_d     = '0;
                        idx_d      = '0;
                        best_d     = '0;
                        second_d   = '0;
                        best_idx_d = '0;
                        state_d    = ST_SCAN;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                // Strictly-greater replacement keeps ties on the lower index.
                if (rd_data > best_q) begin
                    best_d     = rd_data;
                    second_d   = best_q;
                    best_idx_d = idx_q;
                end else if (rd_data > second_q) begin
                    second_d = rd_data;
                end
                if (idx_q == LAST_IDX) state_d = ST_DECIDE;
                else                   idx_d   = idx_q + 1'b1;
            end
            ST_DECIDE: begin
                if ((best_q >= MIN_COUNT_C) && ((best_q - second_q) >= MIN_MARGIN_C)) begin
                    id_d    = best_idx_q;
                    conf_d  = best_q;
                    valid_d = 1'b1;
                    state_d = ST_EMIT;
                end else begin
                    reject_d = 1'b1;
                    clear    = 1'b1;
                    state_d  = ST_ACCUM;
                end
            end
            ST_EMIT: begin
                if (cmd_out_ready) begin
                    valid_d = 1'b0;
                    clear   = 1'b1;
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_ACCUM;
            step_q        <= '0;
            idx_q         <= '0;
            best_q        <= '0;
            second_q      <= '0;
            best_idx_q    <= '0;
            cmd_id        <= '0;
            cmd_conf      <= '0;
            cmd_out_valid <= 1'b0;
            cmd_reject    <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            idx_q         <= idx_d;
            best_q        <= best_d;
            second_q      <= second_d;
            best_idx_q    <= best_idx_d;
            cmd_id        <= id_d;
            cmd_conf      <= conf_d;
            cmd_out_valid <= valid_d;
            cmd_reject    <= reject_d;
            overrun       <= overrun_d;
        end
    end
endmodule

// File: tb/tb_snn_command_decoder.sv
// Scoreboard bench: stimulus pushes hand-computed decisions, per-DUT monitors
// pop and compare them whenever a decision or reject appears.
module tb_snn_command_decoder;
    import snn_pkg::*;

    typedef struct {
        bit rej;
        int id;
        int conf;
        int cyc;
    } exp_t;
    typedef int cnt_arr_t [NUM_CMDS];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset_n;
    logic [NUM_CMDS-1:0] spikes_a, spikes_b;
    logic                valid_a, valid_b, ready_a, ready_b;
    logic [3:0]          id_a, id_b;
    logic [7:0]          conf_a;
    logic [3:0]          conf_b;
    logic                out_valid_a, out_valid_b, rej_a, rej_b, ovr_a, ovr_b;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ovr_seen_a = 0, ovr_seen_b = 0, ovr_exp_a = 0;
    exp_t q_a[$], q_b[$];
    exp_t cur_a, cur_b;
    bit   pv_a = 1'b0, pv_b = 1'b0;

    snn_command_decoder dut_a (
        .clk(clk), .reset_n(reset_n), .cmd_spikes(spikes_a), .cmd_valid(valid_a),
        .cmd_id(id_a), .cmd_conf(conf_a), .cmd_out_valid(out_valid_a),
        .cmd_out_ready(ready_a), .cmd_reject(rej_a), .overrun(ovr_a)
    );

    snn_command_decoder #(.WINDOW(15), .COUNT_W(4), .MIN_COUNT(8), .MIN_MARGIN(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .cmd_spikes(spikes_b), .cmd_valid(valid_b),
        .cmd_id(id_b), .cmd_conf(conf_b), .cmd_out_valid(out_valid_b),
        .cmd_out_ready(ready_b), .cmd_reject(rej_b), .overrun(ovr_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (!reset_n) begin
            pv_a = 1'b0;
        end else begin
            if (ovr_a) ovr_seen_a++;
            if (rej_a || (out_valid_a && !pv_a)) begin
                check("a_event_expected", int'(q_a.size() > 0), 1);
                if (q_a.size() > 0) begin
                    cur_a = q_a.pop_front();
                    check("a_reject", int'(rej_a), int'(cur_a.rej));
                    check("a_latency", cyc, cur_a.cyc);
                    if (!cur_a.rej) begin
                        check("a_cmd_id", int'(id_a), cur_a.id);
                        check("a_cmd_conf", int'(conf_a), cur_a.conf);
                    end
                end
            end else if (out_valid_a) begin
                check("a_id_stable", int'(id_a), cur_a.id);
                check("a_conf_stable", int'(conf_a), cur_a.conf);
            end else if (pv_a) begin
                check("a_drop_without_ready", int'(ready_a), 1);
            end
            pv_a = out_valid_a;
        end
    end

    always @(posedge clk) begin
        #2;
        if (!reset_n) begin
            pv_b = 1'b0;
        end else begin
            if (ovr_b) ovr_seen_b++;
            if (rej_b || (out_valid_b && !pv_b)) begin
                check("b_event_expected", int'(q_b.size() > 0), 1);
                if (q_b.size() > 0) begin
                    cur_b = q_b.pop_front();
                    check("b_reject", int'(rej_b), int'(cur_b.rej));
                    check("b_latency", cyc, cur_b.cyc);
                    if (!cur_b.rej) begin
                        check("b_cmd_id", int'(id_b), cur_b.id);
                        check("b_cmd_conf", int'(conf_b), cur_b.conf);
                    end
                end
            end
            pv_b = out_valid_b;
        end
    end

    // Beat i carries a spike on class j while i < c[j]; returns the edge of the last beat.
    task automatic drive_window(input bit to_b, input cnt_arr_t c, output int k);
        int win;
        win = to_b ? 15 : 64;
        for (int i = 0; i < win; i++) begin
            @(negedge clk);
            for (int j = 0; j < NUM_CMDS; j++) begin
                if (to_b) spikes_b[j] = (i < c[j]);
                else      spikes_a[j] = (i < c[j]);
            end
            if (to_b) valid_b = 1'b1;
            else      valid_a = 1'b1;
        end
        k = cyc + 1;
        @(negedge clk);
        valid_a  = 1'b0;
        valid_b  = 1'b0;
        spikes_a = '0;
        spikes_b = '0;
    endtask

    task automatic push_exp(input bit to_b, input bit rej, input int id, input int conf, input int k);
        exp_t e;
        e.rej  = rej;
        e.id   = id;
        e.conf = conf;
        e.cyc  = k + NUM_CMDS + 1;
        if (to_b) q_b.push_back(e);
        else      q_a.push_back(e);
    endtask

    task automatic wait_drain();
        int budget;
        budget = 200;
        while ((q_a.size() + q_b.size()) > 0 && budget > 0) begin
            @(posedge clk);
            #3;
            budget--;
        end
        check("drain_pending", q_a.size() + q_b.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input bit to_b, input cnt_arr_t c, input bit rej, input int id, input int conf);
        int k;
        drive_window(to_b, c, k);
        push_exp(to_b, rej, id, conf, k);
        wait_drain();
    endtask

    initial begin
        cnt_arr_t c;
        int       k;
        int       budget;

        reset_n  = 1'b0;
        spikes_a = '0;
        spikes_b = '0;
        valid_a  = 1'b0;
        valid_b  = 1'b0;
        ready_a  = 1'b1;
        ready_b  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_id", int'(id_a), 0);
        check("rst_cmd_conf", int'(conf_a), 0);
        check("rst_out_valid", int'(out_valid_a), 0);
        check("rst_reject", int'(rej_a), 0);
        check("rst_overrun", int'(ovr_a), 0);
        check("rst_step", int'(dut_a.step_q), 0);
        reset_n = 1'b1;
        @(negedge clk);

        c = '{0, 0, 0, 64, 0, 0, 0, 0, 0, 0};  run(1'b0, c, 1'b0, 3, 64);
        c = '{0, 0, 64, 0, 0, 64, 0, 0, 0, 0}; run(1'b0, c, 1'b1, 0, 0);
        c = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};   run(1'b0, c, 1'b1, 0, 0);
        c = '{12, 0, 0, 0, 0, 0, 0, 0, 0, 8};  run(1'b0, c, 1'b0, 0, 12);
        c = '{11, 0, 0, 0, 0, 0, 0, 0, 0, 8};  run(1'b0, c, 1'b1, 0, 0);
        c = '{0, 0, 0, 0, 0, 8, 0, 0, 0, 0};   run(1'b0, c, 1'b0, 5, 8);
        c = '{0, 0, 0, 0, 0, 7, 0, 0, 0, 0};   run(1'b0, c, 1'b1, 0, 0);

        c = '{15, 0, 0, 0, 0, 0, 0, 0, 0, 0};  run(1'b1, c, 1'b0, 0, 15);
        c = '{0, 10, 0, 0, 0, 0, 0, 10, 0, 0}; run(1'b1, c, 1'b0, 1, 10);

        // Consumer stalls while the core keeps streaming beats.
        ready_a = 1'b0;
        c = '{0, 0, 0, 0, 64, 0, 0, 0, 0, 0};
        drive_window(1'b0, c, k);
        push_exp(1'b0, 1'b0, 4, 64, k);
        budget = 40;
        while (!out_valid_a && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("stall_valid_seen", int'(out_valid_a), 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            valid_a   = (i % 2) == 1;
            spikes_a  = '1;
            ovr_exp_a += i % 2;
        end
        @(negedge clk);
        valid_a  = 1'b0;
        spikes_a = '0;
        ready_a  = 1'b1;
        wait_drain();
        c = '{0, 0, 0, 0, 0, 0, 0, 0, 64, 0};  run(1'b0, c, 1'b0, 8, 64);

        // Reset while the scan of a full window is in flight.
        c = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 64};
        drive_window(1'b0, c, k);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midscan_cmd_id", int'(id_a), 0);
        check("midscan_cmd_conf", int'(conf_a), 0);
        check("midscan_out_valid", int'(out_valid_a), 0);
        check("midscan_reject", int'(rej_a), 0);
        check("midscan_count9", int'(dut_a.u_bank.count_q[9]), 0);
        check("midscan_step", int'(dut_a.step_q), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        c = '{0, 0, 0, 0, 0, 0, 64, 0, 0, 30}; run(1'b0, c, 1'b0, 6, 64);

        repeat (3) @(negedge clk);
        check("a_overrun_pulses", ovr_seen_a, ovr_exp_a);
        check("b_overrun_pulses", ovr_seen_b, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
